// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage and data memory.
//   dmem_req   : access request, held until dmem_ready
//   dmem_we    : 1 = write, 0 = read
//   dmem_addr  : word-aligned byte address
//   dmem_be    : byte-lane enables
//   dmem_wdata : lane-aligned store data
//   dmem_ready : request accepted/completed this cycle
//   dmem_rdata : read word, valid when dmem_ready
// master = pipeline stage, slave = memory.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register and data-memory access stage (RV32I).
// Latches EX results, runs a req/ready access for aligned loads/stores,
// builds store byte enables/lane data, extends load data and stalls
// upstream while an access is outstanding.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   ex_*, inst_ex, pc_ex  : EX-stage results to latch
//   dmem                  : data-memory bus (master side)
//   inst_mem..mem_wd_sel  : latched fields for writeback
//   mem_rf_we             : write enable, gated by stall/misalignment
//   mem_ram_wb            : extended load data
//   mem_stall             : freeze IF/ID/EX
//   mem_misalign          : misaligned access held in this stage
module mem_access_stage #(
    parameter logic [31:0] BUBBLE_INST = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ex_valid,
    input  logic                       ex_flush,
    input  logic [31:0]                inst_ex,
    input  logic [31:0]                pc_ex,
    input  logic [31:0]                ex_alu_c,
    input  logic [31:0]                ex_auipc,
    input  logic [31:0]                ex_rd2,
    input  logic [1:0]                 ex_wd_sel,
    input  logic                       ex_rf_we,
    input  logic                       ex_mem_re,
    input  logic                       ex_mem_we,
    mem_access_stage_if.master         dmem,
    output logic [31:0]                inst_mem,
    output logic [31:0]                pc_mem,
    output logic [31:0]                mem_alu_c,
    output logic [31:0]                mem_auipc,
    output logic [1:0]                 mem_wd_sel,
    output logic                       mem_rf_we,
    output logic [31:0]                mem_ram_wb,
    output logic                       mem_stall,
    output logic                       mem_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] inst_r, pc_r, alu_c_r, auipc_r, rd2_r, load_r;
    logic [1:0]  wd_sel_r;
    logic        rf_we_r, re_r, we_r;
    logic        advance, capture_access;
    logic [31:0] load_ext;

    // Loads win when both re and we are set, so alignment follows the
    // load funct3 decoding in that case.
    function automatic logic aligned(input logic [2:0] f3, input logic is_load,
                                     input logic [1:0] a);
        logic byte_op, half_op;
        byte_op = is_load ? (f3 == 3'b000 || f3 == 3'b100) : (f3 == 3'b000);
        half_op = is_load ? (f3 == 3'b001 || f3 == 3'b101) : (f3 == 3'b001);
        if (byte_op)
            return 1'b1;
        else if (half_op)
            return ~a[0];
        else
            return (a == 2'b00);
    endfunction

    assign advance        = (state_q != REQ);
    assign capture_access = ex_valid & ~ex_flush & (ex_mem_re | ex_mem_we) &
                            aligned(inst_ex[14:12], ex_mem_re, ex_alu_c[1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = capture_access ? REQ : IDLE;
            REQ:        if (dmem.dmem_ready) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted  = dmem.dmem_rdata >> {alu_c_r[1:0], 3'b000};
        b        = shifted[7:0];
        h        = alu_c_r[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        load_ext = dmem.dmem_rdata;
        case (inst_r[14:12])
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'h0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'h0, h};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_r   <= BUBBLE_INST;
            pc_r     <= '0;
            alu_c_r  <= '0;
            auipc_r  <= '0;
            rd2_r    <= '0;
            wd_sel_r <= '0;
            rf_we_r  <= 1'b0;
            re_r     <= 1'b0;
            we_r     <= 1'b0;
            load_r   <= '0;
        end else if (advance) begin
            if (ex_valid && !ex_flush) begin
                inst_r   <= inst_ex;
                pc_r     <= pc_ex;
                alu_c_r  <= ex_alu_c;
                auipc_r  <= ex_auipc;
                rd2_r    <= ex_rd2;
                wd_sel_r <= ex_wd_sel;
                rf_we_r  <= ex_rf_we;
                re_r     <= ex_mem_re;
                we_r     <= ex_mem_we;
            end else begin
                inst_r   <= BUBBLE_INST;
                pc_r     <= '0;
                alu_c_r  <= '0;
                auipc_r  <= '0;
                rd2_r    <= '0;
                wd_sel_r <= '0;
                rf_we_r  <= 1'b0;
                re_r     <= 1'b0;
                we_r     <= 1'b0;
            end
        end else if (dmem.dmem_ready && re_r) begin
            load_r <= load_ext;
        end
    end

    // Store lane steering; loads and undefined store widths use the full word.
    always_comb begin
        dmem.dmem_be    = 4'b1111;
        dmem.dmem_wdata = rd2_r;
        if (we_r && !re_r) begin
            case (inst_r[14:12])
                3'b000: begin
                    dmem.dmem_be    = 4'b0001 << alu_c_r[1:0];
                    dmem.dmem_wdata = {4{rd2_r[7:0]}};
                end
                3'b001: begin
                    dmem.dmem_be    = 4'b0011 << {alu_c_r[1], 1'b0};
                    dmem.dmem_wdata = {2{rd2_r[15:0]}};
                end
                default: begin
                    dmem.dmem_be    = 4'b1111;
                    dmem.dmem_wdata = rd2_r;
                end
            endcase
        end
    end

    assign dmem.dmem_req  = (state_q == REQ);
    assign dmem.dmem_we   = we_r & ~re_r;
    assign dmem.dmem_addr = {alu_c_r[31:2], 2'b00};

    assign mem_misalign = (re_r | we_r) & ~aligned(inst_r[14:12], re_r, alu_c_r[1:0]);
    assign mem_stall    = (state_q == REQ);
    assign mem_rf_we    = (state_q != REQ) & rf_we_r & ~mem_misalign;
    assign mem_ram_wb   = load_r;

    assign inst_mem   = inst_r;
    assign pc_mem     = pc_r;
    assign mem_alu_c  = alu_c_r;
    assign mem_auipc  = auipc_r;
    assign mem_wd_sel = wd_sel_r;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_flush;
    logic [31:0] inst_ex, pc_ex, ex_alu_c, ex_auipc, ex_rd2;
    logic [1:0]  ex_wd_sel;
    logic        ex_rf_we, ex_mem_re, ex_mem_we;
    logic [31:0] inst_mem, pc_mem, mem_alu_c, mem_auipc, mem_ram_wb;
    logic [1:0]  mem_wd_sel;
    logic        mem_rf_we, mem_stall, mem_misalign;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_stage_if bus ();

    mem_access_stage #(.BUBBLE_INST(32'h00000013)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_flush     (ex_flush),
        .inst_ex      (inst_ex),
        .pc_ex        (pc_ex),
        .ex_alu_c     (ex_alu_c),
        .ex_auipc     (ex_auipc),
        .ex_rd2       (ex_rd2),
        .ex_wd_sel    (ex_wd_sel),
        .ex_rf_we     (ex_rf_we),
        .ex_mem_re    (ex_mem_re),
        .ex_mem_we    (ex_mem_we),
        .dmem         (bus),
        .inst_mem     (inst_mem),
        .pc_mem       (pc_mem),
        .mem_alu_c    (mem_alu_c),
        .mem_auipc    (mem_auipc),
        .mem_wd_sel   (mem_wd_sel),
        .mem_rf_we    (mem_rf_we),
        .mem_ram_wb   (mem_ram_wb),
        .mem_stall    (mem_stall),
        .mem_misalign (mem_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
        return {17'h0, f3, rd, op};
    endfunction

    task automatic set_ex(input logic [31:0] inst, input logic [31:0] alu,
                          input logic [31:0] rd2, input logic re, input logic we,
                          input logic rf_we, input logic [1:0] wd);
        ex_valid  = 1'b1;
        ex_flush  = 1'b0;
        inst_ex   = inst;
        pc_ex     = 32'h0000_0040;
        ex_alu_c  = alu;
        ex_auipc  = 32'h0000_1000;
        ex_rd2    = rd2;
        ex_re_we(re, we);
        ex_rf_we  = rf_we;
        ex_wd_sel = wd;
    endtask

    task automatic ex_re_we(input logic re, input logic we);
        ex_mem_re = re;
        ex_mem_we = we;
    endtask

    // Called one cycle after the capture edge; counts request cycles
    // and raises ready in the (waits+1)-th one, bounded at 20 cycles.
    task automatic run_access(input string tag, input int waits, input logic [31:0] rdata);
        int cnt = 0;
        while (bus.dmem_req === 1'b1 && cnt < 20) begin
            cnt++;
            bus.dmem_ready = (cnt == waits + 1);
            bus.dmem_rdata = (cnt == waits + 1) ? rdata : 32'hxxxx_xxxx;
            step();
        end
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = '0;
        check({tag, "_req_cycles"}, 32'(cnt), 32'(waits + 1));
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = '0;
        set_ex(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        ex_valid = 1'b0;

        // Reset state
        step();
        step();
        check("rst_inst", inst_mem, 32'h00000013);
        check("rst_req", 32'(bus.dmem_req), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_rf_we", 32'(mem_rf_we), 32'd0);
        check("rst_alu", mem_alu_c, 32'd0);

        // Reset while an access is pending
        rst_n = 1'b1;
        set_ex(mk(3'b010, 5'd5, 7'b0000011), 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 2'b01);
        step();
        check("rreq_req", 32'(bus.dmem_req), 32'd1);
        rst_n = 1'b0;
        step();
        check("rreq_req_drop", 32'(bus.dmem_req), 32'd0);
        check("rreq_stall", 32'(mem_stall), 32'd0);
        check("rreq_inst", inst_mem, 32'h00000013);
        check("rreq_rf_we", 32'(mem_rf_we), 32'd0);

        // lw x5, 0x100 with three wait cycles
        rst_n = 1'b1;
        step();
        check("lw_stall", 32'(mem_stall), 32'd1);
        check("lw_rf_we_pend", 32'(mem_rf_we), 32'd0);
        check("lw_addr", bus.dmem_addr, 32'h100);
        check("lw_we", 32'(bus.dmem_we), 32'd0);
        check("lw_be", 32'(bus.dmem_be), 32'hF);
        run_access("lw", 3, 32'hDEADBEEF);
        check("lw_stall_done", 32'(mem_stall), 32'd0);
        check("lw_rf_we", 32'(mem_rf_we), 32'd1);
        check("lw_wb", mem_ram_wb, 32'hDEADBEEF);
        check("lw_rd", 32'(inst_mem[11:7]), 32'd5);
        check("lw_wdsel", 32'(mem_wd_sel), 32'd1);

        // Sub-word loads from 0x80FF0000
        set_ex(mk(3'b000, 5'd6, 7'b0000011), 32'h103, 32'h0, 1'b1, 1'b0, 1'b1, 2'b01);
        step();
        run_access("lb", 0, 32'h80FF_0000);
        check("lb_wb", mem_ram_wb, 32'hFFFFFF80);
        set_ex(mk(3'b100, 5'd6, 7'b0000011), 32'h103, 32'h0, 1'b1, 1'b0, 1'b1, 2'b01);
        step();
        run_access("lbu", 1, 32'h80FF_0000);
        check("lbu_wb", mem_ram_wb, 32'h00000080);
        set_ex(mk(3'b101, 5'd6, 7'b0000011), 32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 2'b01);
        step();
        run_access("lhu", 0, 32'h80FF_0000);
        check("lhu_wb", mem_ram_wb, 32'h000080FF);
        set_ex(mk(3'b001, 5'd6, 7'b0000011), 32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 2'b01);
        step();
        run_access("lh", 0, 32'h80FF_0000);
        check("lh_wb", mem_ram_wb, 32'hFFFF80FF);

        // sb at 0x201; load register must keep the lh result
        set_ex(mk(3'b000, 5'd0, 7'b0100011), 32'h201, 32'h12345678, 1'b0, 1'b1, 1'b0, 2'b00);
        step();
        check("sb_be", 32'(bus.dmem_be), 32'b0010);
        check("sb_wdata", bus.dmem_wdata, 32'h78787878);
        check("sb_we", 32'(bus.dmem_we), 32'd1);
        check("sb_addr", bus.dmem_addr, 32'h200);
        run_access("sb", 0, 32'h5555_5555);
        check("sb_rf_we", 32'(mem_rf_we), 32'd0);
        check("sb_wb_kept", mem_ram_wb, 32'hFFFF80FF);

        // sh at 0x202
        set_ex(mk(3'b001, 5'd0, 7'b0100011), 32'h202, 32'h12345678, 1'b0, 1'b1, 1'b0, 2'b00);
        step();
        check("sh_be", 32'(bus.dmem_be), 32'b1100);
        check("sh_wdata", bus.dmem_wdata, 32'h56785678);
        run_access("sh", 2, 32'h0);
        check("sh_rf_we", 32'(mem_rf_we), 32'd0);

        // re and we both set behaves as a load
        set_ex(mk(3'b010, 5'd7, 7'b0000011), 32'h300, 32'hAAAA_AAAA, 1'b1, 1'b1, 1'b1, 2'b01);
        step();
        check("rewe_we", 32'(bus.dmem_we), 32'd0);
        check("rewe_be", 32'(bus.dmem_be), 32'hF);
        run_access("rewe", 0, 32'h0BAD_F00D);
        check("rewe_wb", mem_ram_wb, 32'h0BADF00D);

        // Misaligned lw at 0x102
        set_ex(mk(3'b010, 5'd8, 7'b0000011), 32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 2'b01);
        step();
        check("mis_req", 32'(bus.dmem_req), 32'd0);
        check("mis_flag", 32'(mem_misalign), 32'd1);
        check("mis_rf_we", 32'(mem_rf_we), 32'd0);
        check("mis_stall", 32'(mem_stall), 32'd0);

        // addi x3 then a flushed slot
        set_ex(mk(3'b000, 5'd3, 7'b0010011), 32'd7, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00);
        step();
        check("addi_rf_we", 32'(mem_rf_we), 32'd1);
        check("addi_alu", mem_alu_c, 32'd7);
        check("addi_wdsel", 32'(mem_wd_sel), 32'd0);
        check("addi_mis", 32'(mem_misalign), 32'd0);
        check("addi_pc", pc_mem, 32'h40);
        ex_flush = 1'b1;
        step();
        check("flush_rf_we", 32'(mem_rf_we), 32'd0);
        check("flush_inst", inst_mem, 32'h00000013);
        check("flush_alu", mem_alu_c, 32'd0);

        // Invalid EX slot also yields a bubble
        set_ex(mk(3'b000, 5'd4, 7'b0010011), 32'd9, 32'h0, 1'b0, 1'b0, 1'b1, 2'b10);
        ex_valid = 1'b0;
        step();
        check("inv_inst", inst_mem, 32'h00000013);
        check("inv_pc", pc_mem, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- EX/MEM pipeline register plus data-memory access stage of the 5-stage RV32I pipeline, directly upstream of the MEM/WB writeback selector.
- Latches EX results and runs a req/ready handshake to data memory for loads and stores.
- Produces store byte enables, sign/zero-extended load data and the memory-stage signals consumed by writeback.
- Stalls upstream while an access is outstanding.

Parameters:
- BUBBLE_INST, 32'h00000013: instruction word presented on inst_mem for bubbles and after reset (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- ex_valid  in  1  EX holds a real instruction
- ex_flush  in  1  insert bubble instead of EX contents
- inst_ex  in  32  EX instruction; funct3 = inst_ex[14:12]
- pc_ex  in  32  EX PC
- ex_alu_c  in  32  ALU result / memory address
- ex_auipc  in  32  auipc result
- ex_rd2  in  32  store data
- ex_wd_sel  in  2  writeback select: 00 alu, 01 ram, 10 pc+4, 11 auipc
- ex_rf_we  in  1  register write enable
- ex_mem_re  in  1  load
- ex_mem_we  in  1  store
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_ready  in  1  request accepted/completed this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready
- inst_mem  out  32  latched instruction
- pc_mem  out  32  latched PC
- mem_alu_c  out  32  latched ALU result
- mem_auipc  out  32  latched auipc result
- mem_wd_sel  out  2  latched writeback select
- mem_rf_we  out  1  gated write enable
- mem_ram_wb  out  32  extended load data
- mem_stall  out  1  freeze IF/ID/EX
- mem_misalign  out  1  misaligned access in this stage

Behaviour:
- Advance edge: rising clk with rst_n=1 and state != REQ.
  - ex_valid=1, ex_flush=0: capture all ex_* inputs.
  - Otherwise capture a bubble: inst=BUBBLE_INST, rf_we=0, re=we=0, valid=0, other fields 0.
- State machine:
  - IDLE: no access pending.
  - REQ: access pending.
  - DONE: access complete.
  - Transitions:
    - Advance with an aligned load/store captured -> REQ.
    - Advance with anything else -> IDLE.
    - REQ with dmem_ready=1 -> DONE.
    - REQ with dmem_ready=0 -> stay in REQ.
- REQ outputs:
  - dmem_req=1, mem_stall=1, mem_rf_we=0.
  - dmem_addr, dmem_we, dmem_be and dmem_wdata held stable until dmem_ready.
  - On the dmem_ready edge, store the extended dmem_rdata into the load register; stores leave it unchanged.
- IDLE/DONE outputs:
  - dmem_req=0, mem_stall=0.
  - mem_rf_we = latched rf_we & ~mem_misalign.
  - mem_ram_wb = load register.
- Latency: minimum 2 cycles for a memory op (REQ with ready in its first cycle, then DONE); 1 cycle for all other ops.
- Alignment:
  - lh/lhu/sh need addr[0]=0; lw/sw need addr[1:0]=0.
  - A misaligned op issues no request, goes to IDLE, holds mem_misalign=1 for its occupancy and forces mem_rf_we=0.
- Load extract, selected by addr[1:0] / addr[1]:
  - funct3 000 lb: sign-extend byte.
  - funct3 100 lbu: zero-extend byte.
  - funct3 001 lh: sign-extend half.
  - funct3 101 lhu: zero-extend half.
  - funct3 010, and undefined 011/110/111: word.
- Store:
  - sb: be = 4'b0001 << addr[1:0], wdata = {4{rd2[7:0]}}.
  - sh: be = 4'b0011 << {addr[1],1'b0}, wdata = {2{rd2[15:0]}}.
  - sw and undefined funct3: be = 4'b1111, wdata = rd2.
  - Loads drive be = 4'b1111.
- ex_re and ex_we both set: treat as a load.
- ex_flush is sampled only on advance edges; while REQ, upstream holds it.
- Reset (rst_n=0 at an edge, including mid-REQ):
  - state=IDLE, so dmem_req drops the next cycle; the access is abandoned.
  - inst_mem=BUBBLE_INST, all other outputs and registers 0.

Test Plan:
- Reset during REQ with dmem_ready=0 -> next cycle dmem_req=0, mem_stall=0, inst_mem=32'h00000013, mem_rf_we=0.
- Load: lw x5 at addr 0x100, ready after 3 wait cycles, rdata=0xDEADBEEF -> dmem_req high 4 cycles, mem_stall high 4 cycles, mem_rf_we=0 then 1; mem_ram_wb=0xDEADBEEF, inst_mem[11:7]=5.
- Byte loads: lb at addr 0x103, rdata=0x80FF_0000 -> mem_ram_wb=0xFFFFFF80; lbu same address -> 0x00000080; lhu at 0x102 -> 0x000080FF.
- Stores: sb at 0x201, rd2=0x12345678 -> dmem_be=0010, dmem_wdata=0x78787878, dmem_we=1; sh at 0x202 -> be=1100, wdata=0x56785678; no rf write.
- Misaligned lw at 0x102 -> dmem_req stays 0, mem_misalign=1, mem_rf_we=0, no stall.
- Back-to-back addi then flush: addi rd=3, alu_c=7 -> next cycle mem_rf_we=1, mem_alu_c=7, wd_sel=00; following cycle with ex_flush=1 -> mem_rf_we=0, inst_mem=0x00000013.
